// File: rtl/crc8_frame_seq.sv
// ============================================================================
// crc8_frame_seq : frame sequencer chaining a parallel CRC-8 (poly 0x07) over
//                  multi-beat valid/ready frames; emits one result per frame.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module crc8_frame_seq #(
  parameter int         DATA_WIDTH = 64,
  parameter int         MAX_BEATS  = 256,
  parameter logic [7:0] CRC_INIT   = 8'h00,
  parameter logic [7:0] XOR_OUT    = 8'h00
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               s_last,
  input  logic                               s_check,
  input  logic [7:0]                         s_exp_crc,
  input  logic                               s_abort,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [7:0]                         m_crc,
  output logic                               m_err,
  output logic [$clog2(MAX_BEATS+1)-1:0]     m_beats,
  output logic                               m_ovf,
  output logic                               busy
);

  localparam int                CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               m_valid_q, m_valid_d;
  logic [7:0]         m_crc_q, m_crc_d;
  logic               m_err_q, m_err_d;
  logic [CNT_W-1:0]   m_beats_q, m_beats_d;
  logic               m_ovf_q, m_ovf_d;

  logic [7:0]         crc_nxt;
  logic [7:0]         crc_out;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_nxt;

  // MSB-first serial CRC update unrolled across the whole word.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [DATA_WIDTH-1:0] w);
    logic [7:0] r;
    logic       msb;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      msb = r[7] ^ w[i];
      r   = {r[6:0], 1'b0} ^ (msb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      crc_q     <= CRC_INIT;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_crc_q   <= 8'h00;
      m_err_q   <= 1'b0;
      m_beats_q <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
      m_err_q   <= m_err_d;
      m_beats_q <= m_beats_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    m_valid_d = m_valid_q;
    m_crc_d   = m_crc_q;
    m_err_d   = m_err_q;
    m_beats_d = m_beats_q;
    m_ovf_d   = m_ovf_q;
    s_ready   = 1'b0;

    crc_nxt = crc_step(crc_q, s_data);
    crc_out = crc_nxt ^ XOR_OUT;
    cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_nxt = ovf_q | (cnt_q == MAX_CNT);

    unique case (state_q)
      ACCUM: begin
        // Abort takes priority and blocks the coincident beat.
        s_ready = !s_abort;
        if (s_abort) begin
          crc_d = CRC_INIT;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (s_valid) begin
          if (s_last) begin
            m_crc_d   = crc_out;
            m_err_d   = s_check & (crc_out != s_exp_crc);
            m_beats_d = cnt_inc;
            m_ovf_d   = ovf_nxt;
            m_valid_d = 1'b1;
            state_d   = HOLD;
            crc_d     = CRC_INIT;
            cnt_d     = '0;
            ovf_d     = 1'b0;
          end else begin
            crc_d = crc_nxt;
            cnt_d = cnt_inc;
            ovf_d = ovf_nxt;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_err   = m_err_q;
  assign m_beats = m_beats_q;
  assign m_ovf   = m_ovf_q;
  assign busy    = (cnt_q != '0) | (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_crc8_frame_seq.sv
// ============================================================================
// tb_crc8_frame_seq : directed bench over three sequencer instances
//                     (8-bit, 64-bit, and 8-bit with a 4-beat limit).
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crc8_frame_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b0;
  logic [2:0]        s_valid = '0, s_last = '0, s_check = '0, s_abort = '0, m_ready = '0;
  logic [2:0]        s_ready, m_valid, m_err, m_ovf, busy;
  logic [2:0][63:0]  s_data = '0;
  logic [2:0][7:0]   s_exp = '0;
  logic [2:0][7:0]   m_crc;
  logic [8:0]        beats0, beats1;
  logic [2:0]        beats2;
  logic [7:0]        msg [9];
  int                tests = 0;
  int                fails = 0;

  crc8_frame_seq #(.DATA_WIDTH(8), .MAX_BEATS(256)) u_d8 (
    .clk(clk), .reset(reset), .s_data(s_data[0][7:0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_last(s_last[0]), .s_check(s_check[0]), .s_exp_crc(s_exp[0]), .s_abort(s_abort[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_crc(m_crc[0]), .m_err(m_err[0]),
    .m_beats(beats0), .m_ovf(m_ovf[0]), .busy(busy[0]));

  crc8_frame_seq #(.DATA_WIDTH(64), .MAX_BEATS(256)) u_d64 (
    .clk(clk), .reset(reset), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_last(s_last[1]), .s_check(s_check[1]), .s_exp_crc(s_exp[1]), .s_abort(s_abort[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_crc(m_crc[1]), .m_err(m_err[1]),
    .m_beats(beats1), .m_ovf(m_ovf[1]), .busy(busy[1]));

  crc8_frame_seq #(.DATA_WIDTH(8), .MAX_BEATS(4)) u_d8s (
    .clk(clk), .reset(reset), .s_data(s_data[2][7:0]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .s_last(s_last[2]), .s_check(s_check[2]), .s_exp_crc(s_exp[2]), .s_abort(s_abort[2]),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_crc(m_crc[2]), .m_err(m_err[2]),
    .m_beats(beats2), .m_ovf(m_ovf[2]), .busy(busy[2]));

  // Byte-serial reference CRC, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       msb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      msb = r[7] ^ d[i];
      r   = {r[6:0], 1'b0} ^ (msb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int u, input logic [63:0] d, input logic last,
                      input logic chk, input logic [7:0] exp);
    s_data[u]  = d;
    s_valid[u] = 1'b1;
    s_last[u]  = last;
    s_check[u] = chk;
    s_exp[u]   = exp;
    tick();
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
    s_check[u] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++; if ({m_valid[0], m_err[0], m_ovf[0], busy[0]} !== 4'b0000) begin
      fails++; $display("FAIL rst_flags: got %b want 0000", {m_valid[0], m_err[0], m_ovf[0], busy[0]}); end
    tests++; if (m_crc[0] !== 8'h00 || beats0 !== 9'd0) begin
      fails++; $display("FAIL rst_fields: got crc=%h beats=%0d want 00/0", m_crc[0], beats0); end
    tests++; if (s_ready !== 3'b111) begin
      fails++; $display("FAIL rst_ready: got %b want 111", s_ready); end
  endtask

  task automatic test_check_vector;
    m_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) beat(0, 64'(msg[i]), 1'b0, 1'b0, 8'h00);
    tests++; if (busy[0] !== 1'b1 || m_valid[0] !== 1'b0) begin
      fails++; $display("FAIL vec_mid: got busy=%b valid=%b want 1/0", busy[0], m_valid[0]); end
    beat(0, 64'(msg[8]), 1'b1, 1'b0, 8'h00);
    tests++; if (m_valid[0] !== 1'b1 || m_crc[0] !== 8'hF4) begin
      fails++; $display("FAIL vec_crc: got valid=%b crc=%h want 1/f4", m_valid[0], m_crc[0]); end
    tests++; if (beats0 !== 9'd9 || m_err[0] !== 1'b0 || m_ovf[0] !== 1'b0) begin
      fails++; $display("FAIL vec_meta: got beats=%0d err=%b ovf=%b want 9/0/0", beats0, m_err[0], m_ovf[0]); end
    tick();
    tests++; if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      fails++; $display("FAIL vec_done: got valid=%b ready=%b busy=%b want 0/1/0", m_valid[0], s_ready[0], busy[0]); end
  endtask

  task automatic test_compare;
    beat(0, 64'h01, 1'b1, 1'b1, 8'h07);
    tests++; if (m_crc[0] !== 8'h07 || m_err[0] !== 1'b0) begin
      fails++; $display("FAIL cmp_match: got crc=%h err=%b want 07/0", m_crc[0], m_err[0]); end
    tick();
    beat(0, 64'h01, 1'b1, 1'b1, 8'h08);
    tests++; if (m_crc[0] !== 8'h07 || m_err[0] !== 1'b1) begin
      fails++; $display("FAIL cmp_miss: got crc=%h err=%b want 07/1", m_crc[0], m_err[0]); end
    tick();
  endtask

  task automatic test_wide;
    logic [7:0]  b [16];
    logic [7:0]  exp;
    logic [63:0] w0, w1;
    w0 = 64'h3132333435363738;
    w1 = {8'h39, 56'h0};
    for (int i = 0; i < 8; i++) begin
      b[i]     = w0[63 - 8*i -: 8];
      b[i + 8] = w1[63 - 8*i -: 8];
    end
    exp = 8'h00;
    for (int i = 0; i < 16; i++) exp = crc8_byte(exp, b[i]);
    m_ready[1] = 1'b1;
    beat(1, w0, 1'b0, 1'b0, 8'h00);
    beat(1, w1, 1'b1, 1'b0, 8'h00);
    tests++; if (m_valid[1] !== 1'b1 || m_crc[1] !== exp || beats1 !== 9'd2) begin
      fails++; $display("FAIL wide_crc: got valid=%b crc=%h beats=%0d want 1/%h/2", m_valid[1], m_crc[1], beats1, exp); end
    tick();
  endtask

  task automatic test_back_pressure;
    m_ready[0] = 1'b0;
    beat(0, 64'h01, 1'b1, 1'b0, 8'h00);
    // Offer a competing beat throughout the hold; it must be ignored.
    s_data[0]  = 64'hFF;
    s_valid[0] = 1'b1;
    s_last[0]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++; if (s_ready[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_crc[0] !== 8'h07 || beats0 !== 9'd1) begin
        fails++; $display("FAIL bp_hold%0d: got ready=%b valid=%b crc=%h beats=%0d want 0/1/07/1",
                          k, s_ready[0], m_valid[0], m_crc[0], beats0); end
      tick();
    end
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    m_ready[0] = 1'b1;
    tick();
    tests++; if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
      fails++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", m_valid[0], s_ready[0]); end
    beat(0, 64'h01, 1'b1, 1'b0, 8'h00);
    tests++; if (m_crc[0] !== 8'h07 || beats0 !== 9'd1) begin
      fails++; $display("FAIL bp_next: got crc=%h beats=%0d want 07/1", m_crc[0], beats0); end
    tick();
  endtask

  task automatic test_abort;
    beat(0, 64'hAA, 1'b0, 1'b0, 8'h00);
    beat(0, 64'hBB, 1'b0, 1'b0, 8'h00);
    beat(0, 64'hCC, 1'b0, 1'b0, 8'h00);
    s_data[0]  = 64'hDD;
    s_valid[0] = 1'b1;
    s_abort[0] = 1'b1;
    #1;
    tests++; if (s_ready[0] !== 1'b0) begin
      fails++; $display("FAIL abort_ready: got %b want 0", s_ready[0]); end
    tick();
    s_valid[0] = 1'b0;
    s_abort[0] = 1'b0;
    tests++; if (busy[0] !== 1'b0 || m_valid[0] !== 1'b0) begin
      fails++; $display("FAIL abort_idle: got busy=%b valid=%b want 0/0", busy[0], m_valid[0]); end
    for (int i = 0; i < 9; i++) beat(0, 64'(msg[i]), i == 8, 1'b0, 8'h00);
    tests++; if (m_crc[0] !== 8'hF4 || beats0 !== 9'd9) begin
      fails++; $display("FAIL abort_frame: got crc=%h beats=%0d want f4/9", m_crc[0], beats0); end
    tick();
  endtask

  task automatic test_ovf_reset;
    logic [7:0] exp;
    exp = 8'h00;
    for (int i = 0; i < 6; i++) exp = crc8_byte(exp, 8'(i + 1));
    m_ready[2] = 1'b1;
    for (int i = 0; i < 6; i++) beat(2, 64'(i + 1), i == 5, 1'b0, 8'h00);
    tests++; if (m_valid[2] !== 1'b1 || beats2 !== 3'd4 || m_ovf[2] !== 1'b1 || m_crc[2] !== exp) begin
      fails++; $display("FAIL ovf_res: got valid=%b beats=%0d ovf=%b crc=%h want 1/4/1/%h",
                        m_valid[2], beats2, m_ovf[2], m_crc[2], exp); end
    tick();
    beat(2, 64'h11, 1'b0, 1'b0, 8'h00);
    beat(2, 64'h22, 1'b0, 1'b0, 8'h00);
    tests++; if (busy[2] !== 1'b1) begin
      fails++; $display("FAIL ovf_partial: got busy=%b want 1", busy[2]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if ({m_valid[2], m_err[2], m_ovf[2], busy[2]} !== 4'b0000 || m_crc[2] !== 8'h00 || beats2 !== 3'd0) begin
      fails++; $display("FAIL ovf_rst: got flags=%b crc=%h beats=%0d want 0000/00/0",
                        {m_valid[2], m_err[2], m_ovf[2], busy[2]}, m_crc[2], beats2); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (m_valid[2] !== 1'b0 || s_ready[2] !== 1'b1) begin
        fails++; $display("FAIL ovf_idle%0d: got valid=%b ready=%b want 0/1", k, m_valid[2], s_ready[2]); end
    end
    beat(2, 64'h01, 1'b1, 1'b0, 8'h00);
    tests++; if (m_valid[2] !== 1'b1 || m_crc[2] !== 8'h07 || beats2 !== 3'd1 || m_ovf[2] !== 1'b0) begin
      fails++; $display("FAIL ovf_after: got valid=%b crc=%h beats=%0d ovf=%b want 1/07/1/0",
                        m_valid[2], m_crc[2], beats2, m_ovf[2]); end
    tick();
  endtask

  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    test_reset();
    test_check_vector();
    test_compare();
    test_wide();
    test_back_pressure();
    test_abort();
    test_ovf_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
